seq_muldiv: RTL

Multi-cycle signed multiply/divide unit that sits directly downstream of the control FSM's ALU opcode output and beside the single-cycle ALU. It executes MUL and DIV over WIDTH iterations and delivers a 2×WIDTH result split into the halves latched by the Z register. Results are routed to HI and LO. The control FSM holds in its T5 state until `done`.

---
 rtl/cpu_pkg.sv | 32 +++
 rtl/muldiv_sign_adj.sv | 13 +
 rtl/seq_muldiv.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU one-hot opcode indices, datapath width and
// the seq_muldiv state encoding.
package cpu_pkg;

   localparam int unsigned ALU_OP_W     = 16;
   localparam int unsigned MULDIV_WIDTH = 32;

   // One-hot bit positions within alu_op
   localparam int unsigned ALU_ADD  = 0;
   localparam int unsigned ALU_SUB  = 1;
   localparam int unsigned ALU_NEG  = 2;
   localparam int unsigned ALU_MUL  = 3;
   localparam int unsigned ALU_DIV  = 4;
   localparam int unsigned ALU_AND  = 5;
   localparam int unsigned ALU_OR   = 6;
   localparam int unsigned ALU_XOR  = 7;
   localparam int unsigned ALU_NOT  = 8;
   localparam int unsigned ALU_SHL  = 9;
   localparam int unsigned ALU_SHR  = 10;
   localparam int unsigned ALU_SHRA = 11;
   localparam int unsigned ALU_C2   = 12;
   localparam int unsigned ALU_INC  = 13;

   typedef enum logic [2:0] {
      MD_IDLE = 3'd0,
      MD_PREP = 3'd1,
      MD_ITER = 3'd2,
      MD_FIX  = 3'd3,
      MD_DONE = 3'd4
   } md_state_t;

endpackage

// File: rtl/muldiv_sign_adj.sv
// Conditional two's-complement negate; used for operand magnitudes and
// for sign-correcting the final product / quotient / remainder.
module muldiv_sign_adj #(
   parameter int unsigned W = 32
) (
   input  logic         neg,
   input  logic [W-1:0] value,
   output logic [W-1:0] result_c
);

   assign result_c = neg ? (W'(0) - value) : value;

endmodule

// File: rtl/seq_muldiv.sv
// Multi-cycle signed multiply / divide (shift-add, restoring divide).
// Optional macro SEQ_MULDIV_EARLY_OUT_EN skips iteration for zero results.
module seq_muldiv
   import cpu_pkg::*;
#(
   parameter int unsigned WIDTH   = MULDIV_WIDTH,
   parameter int unsigned MUL_IDX = ALU_MUL,
   parameter int unsigned DIV_IDX = ALU_DIV
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                start,
   input  logic [15:0]         alu_op,
   input  logic [WIDTH-1:0]    a,
   input  logic [WIDTH-1:0]    b,
   output logic                busy,
   output logic                done,
   output logic [WIDTH-1:0]    result_hi,
   output logic [WIDTH-1:0]    result_lo,
   output logic                div_by_zero
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   md_state_t state, state_nx;
   logic busy_nx, done_nx;

   logic               op_mul;
   logic [WIDTH-1:0]   op_a, op_b;
   logic [WIDTH-1:0]   opnd;
   logic [WIDTH-1:0]   acc_hi, acc_lo;
   logic [CNT_W-1:0]   cnt;
   logic               neg_res, neg_rem, zero_res;

   logic               accept_c, early_c;
   logic [WIDTH-1:0]   abs_a_c, abs_b_c;
   logic [WIDTH:0]     mul_sum_c;
   logic [WIDTH:0]     div_shift_c;
   logic               div_ge_c;
   logic [WIDTH-1:0]   div_sub_c;
   logic [2*WIDTH-1:0] prod_c;
   logic [WIDTH-1:0]   quo_c, rem_c;

   logic unused_alu_op;
   assign unused_alu_op = ^alu_op;

   assign accept_c = (state == MD_IDLE) && start && (alu_op[MUL_IDX] || alu_op[DIV_IDX]);

`ifdef SEQ_MULDIV_EARLY_OUT_EN
   assign early_c = op_mul ? ((op_a == '0) || (op_b == '0))
                           : ((op_a == '0) && (op_b != '0));
`else
   assign early_c = 1'b0;
`endif

   muldiv_sign_adj #(.W(WIDTH)) u_abs_a (.neg(op_a[WIDTH-1]), .value(op_a), .result_c(abs_a_c));
   muldiv_sign_adj #(.W(WIDTH)) u_abs_b (.neg(op_b[WIDTH-1]), .value(op_b), .result_c(abs_b_c));
   muldiv_sign_adj #(.W(2*WIDTH)) u_fix_prod (.neg(neg_res), .value({acc_hi, acc_lo}), .result_c(prod_c));
   muldiv_sign_adj #(.W(WIDTH)) u_fix_quo (.neg(neg_res), .value(acc_lo), .result_c(quo_c));
   muldiv_sign_adj #(.W(WIDTH)) u_fix_rem (.neg(neg_rem), .value(acc_hi), .result_c(rem_c));

   // One iteration step: multiplier bits consumed from acc_lo LSB; dividend
   // bits shifted out of acc_lo MSB while quotient bits shift in.
   assign mul_sum_c   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : (WIDTH+1)'(0));
   assign div_shift_c = {acc_hi, acc_lo[WIDTH-1]};
   assign div_ge_c    = (div_shift_c >= {1'b0, opnd});
   assign div_sub_c   = WIDTH'(div_shift_c - {1'b0, opnd});

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= MD_IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_nx;
         busy  <= busy_nx;
         done  <= done_nx;
      end
   end

   always_comb begin
      state_nx = state;
      busy_nx  = 1'b0;
      done_nx  = 1'b0;
      case (state)
         MD_IDLE: if (accept_c) state_nx = MD_PREP;
         MD_PREP: state_nx = early_c ? MD_FIX : MD_ITER;
         MD_ITER: if (cnt == CNT_LAST) state_nx = MD_FIX;
         MD_FIX:  state_nx = MD_DONE;
         MD_DONE: state_nx = MD_IDLE;
         default: state_nx = MD_IDLE;
      endcase
      busy_nx = (state_nx != MD_IDLE);
      done_nx = (state_nx == MD_DONE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         op_mul      <= 1'b0;
         op_a        <= '0;
         op_b        <= '0;
         opnd        <= '0;
         acc_hi      <= '0;
         acc_lo      <= '0;
         cnt         <= '0;
         neg_res     <= 1'b0;
         neg_rem     <= 1'b0;
         zero_res    <= 1'b0;
         result_hi   <= '0;
         result_lo   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            MD_IDLE: if (accept_c) begin
               op_mul      <= alu_op[MUL_IDX];
               op_a        <= a;
               op_b        <= b;
               div_by_zero <= 1'b0;
            end
            MD_PREP: begin
               opnd     <= op_mul ? abs_a_c : abs_b_c;
               acc_hi   <= '0;
               acc_lo   <= op_mul ? abs_b_c : abs_a_c;
               cnt      <= '0;
               neg_res  <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
               neg_rem  <= op_a[WIDTH-1];
               zero_res <= early_c;
            end
            MD_ITER: begin
               cnt <= cnt + CNT_W'(1);
               if (op_mul) begin
                  acc_hi <= mul_sum_c[WIDTH:1];
                  acc_lo <= {mul_sum_c[0], acc_lo[WIDTH-1:1]};
               end else begin
                  acc_hi <= div_ge_c ? div_sub_c : div_shift_c[WIDTH-1:0];
                  acc_lo <= {acc_lo[WIDTH-2:0], div_ge_c};
               end
            end
            MD_FIX: begin
               if (zero_res) begin
                  result_hi <= '0;
                  result_lo <= '0;
               end else if (op_mul) begin
                  {result_hi, result_lo} <= prod_c;
               end else if (op_b == '0) begin
                  result_hi   <= op_a;
                  result_lo   <= '1;
                  div_by_zero <= 1'b1;
               end else begin
                  result_hi <= rem_c;
                  result_lo <= quo_c;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
